// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and default baud divisor.
// Used by the transmitter and intended for reuse by the receiver.
package uart_pkg;

    // Frame sequencing states; encodings 5..7 are unreachable.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    // 50 MHz system clock at 115200 baud.
    localparam int CLKS_PER_BIT_DEFAULT = 434;

endpackage

// File: rtl/uart_tx_frame_if.sv
// Word handshake between a byte source (master) and the UART transmitter (slave).
interface uart_tx_frame_if #(
    parameter int DATA_BITS = 8
);
    logic                 send;
    logic [DATA_BITS-1:0] data;
    logic                 ready;
    logic                 busy;
    logic                 done;

    modport master (output send, data, input  ready, busy, done);
    modport slave  (input  send, data, output ready, busy, done);
endinterface

// File: rtl/uart_baud_tick.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last clock of each bit.
// pre_tick marks the clock before tick so a registered output can land on the last clock.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter  int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    localparam int CW           = $clog2(CLKS_PER_BIT)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick,
    output logic pre_tick
);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] PREV = CW'(CLKS_PER_BIT - 2);

    logic [CW-1:0] count;

    assign tick     = (count == LAST);
    assign pre_tick = (count == PREV);

    // Free-running bit counter; wraps on tick and is held at zero by clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear || tick) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end
endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter: start bit, DATA_BITS data bits LSB first, optional parity,
// STOP_BITS stop bits. All outputs, including tx, come straight from flops.
// Optional feature macro: UART_TX_PARITY_EN adds the parity bit (PARITY_ODD selects odd).
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    uart_tx_frame_if.slave  bus,
    output logic            tx
);
    localparam int            BW       = $clog2(DATA_BITS);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    if (CLKS_PER_BIT < 2 || DATA_BITS < 5 || DATA_BITS > 9 ||
        STOP_BITS < 1 || STOP_BITS > 2 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_param
        $error("uart_tx_frame: illegal parameter value");
    end

    uart_state_e          state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [BW-1:0]        bit_q,   bit_d;
    logic                 stop_q,  stop_d;
    logic                 tx_q,    tx_d;
    logic                 ready_q, busy_q, done_q, done_d;
    logic                 tick, pre_tick, baud_clear, stop_last;
`ifdef UART_TX_PARITY_EN
    logic                 parity_q, parity_d;
`endif

    assign stop_last  = (STOP_BITS == 1) ? 1'b1 : stop_q;
    // The bit timer restarts whenever the FSM changes state and stays cleared in IDLE.
    assign baud_clear = (state_q == IDLE) || (state_d != state_q);

    uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (baud_clear),
        .tick     (tick),
        .pre_tick (pre_tick)
    );

    // Next-state, datapath and next-output decode; outputs are decoded from the next state.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
        state_d = state_q;
        shift_d = shift_q;
        bit_d   = bit_q;
        stop_d  = stop_q;
        done_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.send && ready_q) begin
                    state_d = START;
                    shift_d = bus.data;
                    bit_d   = '0;
                    stop_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
                    parity_d = (^bus.data) ^ 1'(PARITY_ODD);
`endif
                end
            end
            START: begin
                if (tick) state_d = DATA;
            end
            DATA: begin
                if (tick) begin
                    if (bit_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_d   = bit_q + BW'(1);
                        shift_d = shift_q >> 1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (tick) state_d = STOP;
            end
`endif
            STOP: begin
                // Registered done lands on the final clock of the last stop bit.
                if (pre_tick && stop_last) done_d = 1'b1;
                if (tick) begin
                    if (stop_last) state_d = IDLE;
                    else           stop_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_d = parity_q;
`endif
            default: tx_d = 1'b1;
        endcase
    end

    // State, datapath and output registers; reset aborts any frame and idles the line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            shift_q <= '0;
            bit_q   <= '0;
            stop_q  <= 1'b0;
            tx_q    <= 1'b1;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q <= state_d;
            shift_q <= shift_d;
            bit_q   <= bit_d;
            stop_q  <= stop_d;
            tx_q    <= tx_d;
            ready_q <= (state_d == IDLE);
            busy_q  <= (state_d != IDLE);
            done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    assign tx        = tx_q;
    assign bus.ready = ready_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
endmodule

// File: tb/tb_uart_tx_frame.sv
// Scoreboard bench for uart_tx_frame: stimulus pushes hand-written line levels
// (one character per bit, first transmitted first); a monitor captures each frame.
module tb_uart_tx_frame;
    localparam int CLKS = 4;

`ifdef UART_TX_PARITY_EN
    localparam string LV_A5  = "01010010101";
    localparam string LV_00  = "00000000001";
    localparam string LV_FF  = "01111111101";
    localparam string LV_55  = "01010101001";
    localparam string LV_07A = "01110000011";
    localparam string LV_07B = "01110000011";
    localparam string LV_7FB = "01111111011";
    localparam string LV_C3  = "01100001101";
    localparam string LV_81  = "01000000101";
`else
    localparam string LV_A5  = "0101001011";
    localparam string LV_00  = "0000000001";
    localparam string LV_FF  = "0111111111";
    localparam string LV_55  = "0101010101";
    localparam string LV_07A = "0111000001";
    localparam string LV_07B = "0111000011";
    localparam string LV_7FB = "0111111111";
    localparam string LV_C3  = "0110000111";
    localparam string LV_81  = "0100000011";
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic tx_a, tx_b;

    uart_tx_frame_if #(.DATA_BITS(8)) bus_a ();
    uart_tx_frame_if #(.DATA_BITS(7)) bus_b ();

    uart_tx_frame #(.CLKS_PER_BIT(CLKS), .DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a), .tx(tx_a));
    uart_tx_frame #(.CLKS_PER_BIT(CLKS), .DATA_BITS(7), .STOP_BITS(2), .PARITY_ODD(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b), .tx(tx_b));

    always #5 clk = ~clk;

    typedef struct {
        string levels;
        bit    abort;
        int    gap;
    } frame_t;

    frame_t sb_q[$];
    int     n_tests = 0;
    int     n_fail = 0;
    int     stray_done = 0;
    bit     sel = 1'b0;
    bit     mon_active = 1'b0;

    logic m_tx, m_ready, m_busy, m_done;
    assign m_tx    = sel ? tx_b         : tx_a;
    assign m_ready = sel ? bus_b.ready  : bus_a.ready;
    assign m_busy  = sel ? bus_b.busy   : bus_a.busy;
    assign m_done  = sel ? bus_b.done   : bus_a.done;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] expand(input string lv);
        logic [63:0] w;
        w = '0;
        for (int i = 0; i < lv.len() * CLKS; i++) w[i] = (lv[i / CLKS] == "1");
        return w;
    endfunction

    // Monitor: a falling tx edge opens a frame, which is captured clock by clock and scored.
    initial begin : monitor
        logic prev_tx;
        int   gap;
        prev_tx = 1'b1;
        gap     = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_tx = 1'b1;
                gap     = 0;
            end else if (prev_tx && !m_tx) begin : capture
                frame_t      e;
                logic [63:0] act;
                int          fl, done_at, n_done, n_rdy, n_nbusy;
                bit          aborted;
                mon_active = 1'b1;
                if (sb_q.size() == 0) begin
                    check("queue_depth_at_frame_start", 64'(sb_q.size()), 64'd1);
                    e.levels = "1111111111";
                    e.abort  = 1'b0;
                    e.gap    = -1;
                end else begin
                    e = sb_q.pop_front();
                end
                fl = e.levels.len() * CLKS;
                act = '0; done_at = 0; n_done = 0; n_rdy = 0; n_nbusy = 0; aborted = 1'b0;
                for (int k = 1; k <= fl; k++) begin
                    if (k > 1) @(negedge clk);
                    if (!rst_n) begin
                        aborted = 1'b1;
                        break;
                    end
                    act[k-1] = m_tx;
                    if (m_done) begin
                        n_done++;
                        done_at = k;
                    end
                    if (m_ready) n_rdy++;
                    if (!m_busy) n_nbusy++;
                end
                check("frame_aborted", 64'(aborted), 64'(e.abort));
                if (aborted) begin
                    check("abort_done_count", 64'(n_done), 64'd0);
                    gap     = 0;
                    prev_tx = 1'b1;
                end else begin
                    check("frame_wave", act, expand(e.levels));
                    check("done_clock", 64'(done_at), 64'(fl));
                    check("done_count", 64'(n_done), 64'd1);
                    check("ready_high_in_frame", 64'(n_rdy), 64'd0);
                    check("busy_low_in_frame", 64'(n_nbusy), 64'd0);
                    if (e.gap >= 0) check("idle_gap", 64'(gap), 64'(e.gap));
                    @(negedge clk);
                    check("post_frame_ready_busy_tx", 64'({m_ready, m_busy, m_tx}), 64'b101);
                    if (m_done) stray_done++;
                    gap     = m_tx ? 1 : 0;
                    prev_tx = m_tx;
                end
                mon_active = 1'b0;
            end else begin
                if (m_done) stray_done++;
                if (m_tx) gap++;
                prev_tx = m_tx;
            end
        end
    end

    // Drive a word on the selected bus, wait for acceptance, then scramble data.
    task automatic send_word(input logic [8:0] w, input bit keep, input string lv,
                             input bit ab, input int gap);
        bit ok;
        ok = 1'b0;
        if (sel) begin bus_b.send = 1'b1; bus_b.data = w[6:0]; end
        else     begin bus_a.send = 1'b1; bus_a.data = w[7:0]; end
        for (int n = 0; n < 200; n++) begin
            if ((sel ? bus_b.ready : bus_a.ready) === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        check("accept_ready", 64'(ok), 64'd1);
        if (ok) begin
            @(posedge clk);
            push_frame(lv, ab, gap);
            #1;
        end
        if (sel) begin bus_b.send = keep; bus_b.data = ~w[6:0]; end
        else     begin bus_a.send = keep; bus_a.data = ~w[7:0]; end
    endtask

    task automatic push_frame(input string lv, input bit ab, input int gap);
        frame_t e;
        e.levels = lv;
        e.abort  = ab;
        e.gap    = gap;
        sb_q.push_back(e);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((sb_q.size() != 0 || mon_active) && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        check({name, "_drain"}, 64'(n < 500), 64'd1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin : stimulus
        bus_a.send = 1'b0; bus_a.data = '0;
        bus_b.send = 1'b0; bus_b.data = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_a", 64'({tx_a, bus_a.ready, bus_a.busy, bus_a.done}), 64'b1100);
        check("reset_b", 64'({tx_b, bus_b.ready, bus_b.busy, bus_b.done}), 64'b1100);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single frame.
        send_word(9'h0A5, 1'b0, LV_A5, 1'b0, -1);
        wait_idle("single");

        // Back-to-back with send held high.
        send_word(9'h000, 1'b1, LV_00, 1'b0, -1);
        send_word(9'h0FF, 1'b0, LV_FF, 1'b0, 1);
        wait_idle("back_to_back");

        // Send while busy is ignored.
        send_word(9'h055, 1'b0, LV_55, 1'b0, -1);
        repeat (9) @(posedge clk);
        #1;
        bus_a.send = 1'b1; bus_a.data = 8'h3C;
        @(posedge clk); #1;
        bus_a.send = 1'b0;
        wait_idle("send_while_busy");

        // Parity-sensitive word on both configurations, then 7-bit / 2-stop frame.
        send_word(9'h007, 1'b0, LV_07A, 1'b0, -1);
        wait_idle("parity_even");
        sel = 1'b1;
        send_word(9'h007, 1'b0, LV_07B, 1'b0, -1);
        wait_idle("parity_odd");
        send_word(9'h07F, 1'b0, LV_7FB, 1'b0, -1);
        wait_idle("two_stop");
        sel = 1'b0;

        // Reset during clock 15 of a frame.
        send_word(9'h0C3, 1'b0, LV_C3, 1'b1, -1);
        repeat (14) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_mid_frame", 64'({tx_a, bus_a.ready, bus_a.busy, bus_a.done}), 64'b1100);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        send_word(9'h081, 1'b0, LV_81, 1'b0, -1);
        wait_idle("after_reset");

        check("stray_done", 64'(stray_done), 64'd0);
        check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1, "tb_uart_tx_frame: time limit");
    end
endmodule
